// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants for the interrupt controller.
//   Exception codes seen on the CP0 exception port, the CP0 register
//   addresses that the optional timer snoops, the default interrupt line
//   count and the FSM state encodings.
//   Optional feature macro used by this block: CP0_TIMER_EN.
package int_ctrl_pkg;

  localparam int INT_NUM = 6;

  // EXC_NONE is a code that no real exception uses, so "no exception"
  // can travel on the same 5-bit bus as the real codes.
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ERET = 5'h0e;
  localparam logic [4:0] EXC_NONE = 5'h1f;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;

  typedef enum logic {
    INT_IDLE    = 1'b0,
    INT_HANDLER = 1'b1
  } int_state_e;

endpackage

// File: rtl/int_sync.sv
// int_sync: single-bit, SYNC_STAGES-deep flip-flop synchronizer for one
//   asynchronous interrupt line.
// Ports:
//   cpu_clk_50M  in   system clock
//   cpu_rst      in   synchronous reset, active-high (clears every stage)
//   d_i          in   raw asynchronous level
//   q_o          out  level delayed by SYNC_STAGES clocks
module int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic cpu_clk_50M,
  input  logic cpu_rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt scheduler in front of the CP0 register block.
//   Synchronizes the device interrupt lines, masks them with Status
//   IM/IE/EXL and injects EXC_INT only on a valid, unstalled MEM-stage
//   instruction that carries no synchronous exception. One interrupt is
//   issued per handler: after a take the FSM waits for EXL to rise and
//   then fall (ERET) before it may issue again.
//   Optional macro CP0_TIMER_EN adds a COUNT/COMPARE timer whose request
//   is ORed into the highest interrupt line.
// Ports:
//   cpu_clk_50M    in   system clock
//   cpu_rst        in   synchronous reset, active-high
//   int_i          in   raw level-sensitive device interrupts
//   status_i       in   CP0 Status ([0]=IE, [1]=EXL, [15:10]=IM)
//   mem_valid_i    in   MEM stage holds a real instruction
//   mem_stall_i    in   MEM stage stalled this cycle
//   mem_exccode_i  in   synchronous exception code from MEM
//   cp0_we_i       in   CP0 write strobe (timer build only)
//   cp0_waddr_i    in   CP0 write address (timer build only)
//   cp0_wdata_i    in   CP0 write data (timer build only)
//   exccode_o      out  exception code to CP0
//   int_pending_o  out  synchronized pending vector (Cause.IP)
//   int_ack_o      out  one-hot pulse naming the line taken
//   in_handler_o   out  high while an interrupt handler is running
module int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int INT_NUM     = 6
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic [INT_NUM-1:0] int_i,
  input  logic [31:0]        status_i,
  input  logic               mem_valid_i,
  input  logic               mem_stall_i,
  input  logic [4:0]         mem_exccode_i,
  input  logic               cp0_we_i,
  input  logic [4:0]         cp0_waddr_i,
  input  logic [31:0]        cp0_wdata_i,
  output logic [4:0]         exccode_o,
  output logic [INT_NUM-1:0] int_pending_o,
  output logic [INT_NUM-1:0] int_ack_o,
  output logic               in_handler_o
);
  import int_ctrl_pkg::*;

  logic [INT_NUM-1:0] sync_q;
  logic [INT_NUM-1:0] enabled;
  logic [INT_NUM-1:0] ack_prio;
  logic [INT_NUM-1:0] ack_reg, ack_next;
  logic               take;
  int_state_e         state_reg, state_next;
  logic               seen_exl_reg, seen_exl_next;

  genvar gi;
  generate
    for (gi = 0; gi < INT_NUM; gi++) begin : g_sync
      int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .d_i         (int_i[gi]),
        .q_o         (sync_q[gi])
      );
    end
  endgenerate

`ifdef CP0_TIMER_EN
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        tick_reg;
  logic        timer_ip_reg;

  // COUNT advances at half the core clock; loading COUNT also realigns
  // the half-rate phase so the compare time is predictable from the write.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      count_reg    <= '0;
      compare_reg  <= '0;
      tick_reg     <= 1'b0;
      timer_ip_reg <= 1'b0;
    end else begin
      tick_reg <= ~tick_reg;
      if (cp0_we_i && cp0_waddr_i == CP0_COUNT) begin
        count_reg <= cp0_wdata_i;
        tick_reg  <= 1'b0;
      end else if (tick_reg) begin
        count_reg <= count_reg + 32'd1;
      end
      if (cp0_we_i && cp0_waddr_i == CP0_COMPARE) begin
        compare_reg  <= cp0_wdata_i;
        timer_ip_reg <= 1'b0;
      end else if (count_reg == compare_reg && compare_reg != 32'd0) begin
        timer_ip_reg <= 1'b1;
      end
    end
  end

  // The timer is already in this clock domain, so it bypasses the synchronizer.
  assign int_pending_o = sync_q | {timer_ip_reg, {(INT_NUM-1){1'b0}}};

  logic unused_status;
  assign unused_status = ^{status_i[31:10+INT_NUM], status_i[9:2]};
`else
  assign int_pending_o = sync_q;

  logic unused_inputs;
  assign unused_inputs = ^{cp0_we_i, cp0_waddr_i, cp0_wdata_i,
                           status_i[31:10+INT_NUM], status_i[9:2]};
`endif

  assign enabled = int_pending_o & status_i[10 +: INT_NUM];

  assign take = ~cpu_rst && (state_reg == INT_IDLE) && status_i[0] && ~status_i[1]
              && (|enabled) && mem_valid_i && ~mem_stall_i
              && (mem_exccode_i == EXC_NONE);

  // Synchronous exceptions (including ERET) always take precedence.
  always_comb begin
    exccode_o = EXC_NONE;
    if (cpu_rst) begin
      exccode_o = EXC_NONE;
    end else if (mem_exccode_i != EXC_NONE) begin
      exccode_o = mem_exccode_i;
    end else if (take) begin
      exccode_o = EXC_INT;
    end
  end

  // Highest enabled index wins: later iterations overwrite earlier ones.
  always_comb begin
    ack_prio = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (enabled[i]) begin
        ack_prio    = '0;
        ack_prio[i] = 1'b1;
      end
    end
  end

  // The handler is considered finished only once EXL has been observed
  // high and then low again, so a take before CP0 raises EXL cannot
  // immediately bounce the FSM back to IDLE.
  always_comb begin
    state_next    = state_reg;
    seen_exl_next = seen_exl_reg;
    ack_next      = '0;
    case (state_reg)
      INT_IDLE: begin
        seen_exl_next = 1'b0;
        if (take) begin
          state_next = INT_HANDLER;
          ack_next   = ack_prio;
        end
      end
      INT_HANDLER: begin
        if (status_i[1]) begin
          seen_exl_next = 1'b1;
        end else if (seen_exl_reg) begin
          state_next    = INT_IDLE;
          seen_exl_next = 1'b0;
        end
      end
      default: begin
        state_next    = INT_IDLE;
        seen_exl_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_reg    <= INT_IDLE;
      seen_exl_reg <= 1'b0;
      ack_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      seen_exl_reg <= seen_exl_next;
      ack_reg      <= ack_next;
    end
  end

  assign int_ack_o    = ack_reg;
  assign in_handler_o = (state_reg == INT_HANDLER);

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl.
//   Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
//   The timer scenario is compiled in only when CP0_TIMER_EN is defined.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int NL = 6;

  logic          clk;
  logic          rst;
  logic [NL-1:0] int_i;
  logic [31:0]   status;
  logic          mem_valid;
  logic          mem_stall;
  logic [4:0]    mem_exc;
  logic          cp0_we;
  logic [4:0]    cp0_waddr;
  logic [31:0]   cp0_wdata;
  logic [4:0]    exccode;
  logic [NL-1:0] pending;
  logic [NL-1:0] ack;
  logic          in_handler;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl #(.SYNC_STAGES(2), .INT_NUM(NL)) dut (
    .cpu_clk_50M   (clk),
    .cpu_rst       (rst),
    .int_i         (int_i),
    .status_i      (status),
    .mem_valid_i   (mem_valid),
    .mem_stall_i   (mem_stall),
    .mem_exccode_i (mem_exc),
    .cp0_we_i      (cp0_we),
    .cp0_waddr_i   (cp0_waddr),
    .cp0_wdata_i   (cp0_wdata),
    .exccode_o     (exccode),
    .int_pending_o (pending),
    .int_ack_o     (ack),
    .in_handler_o  (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leave a handler cleanly: drop the line, raise then lower EXL.
  task automatic exit_handler(input string tag);
    int_i  = '0;
    status = status | 32'h2;
    tick();
    status = status & ~32'h2;
    tick();
    settle();
    check({tag, "_exit_in_handler"}, 32'(in_handler), 32'd0);
    check({tag, "_exit_exccode"}, 32'(exccode), 32'(EXC_NONE));
  endtask

  initial begin
    rst       = 1'b1;
    int_i     = '1;
    status    = 32'h0;
    mem_valid = 1'b0;
    mem_stall = 1'b0;
    mem_exc   = EXC_NONE;
    cp0_we    = 1'b0;
    cp0_waddr = 5'd0;
    cp0_wdata = 32'd0;

    // Reset holds everything at zero even with all lines high.
    tick(); tick(); tick();
    settle();
    check("rst_exccode", 32'(exccode), 32'(EXC_NONE));
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_in_handler", 32'(in_handler), 32'd0);
    int_i = '0;
    tick();
    rst = 1'b0;
    tick(); tick();

    // 1: single line, EXC_INT exactly two cycles after the line rises.
    int_i     = 6'b000100;
    status    = 32'h0000_1001;
    mem_valid = 1'b1;
    settle();
    check("t1_c0_exccode", 32'(exccode), 32'(EXC_NONE));
    tick(); settle();
    check("t1_c1_exccode", 32'(exccode), 32'(EXC_NONE));
    check("t1_c1_pending", 32'(pending), 32'd0);
    tick(); settle();
    check("t1_c2_pending", 32'(pending), 32'b000100);
    check("t1_c2_exccode", 32'(exccode), 32'(EXC_INT));
    tick(); settle();
    check("t1_ack", 32'(ack), 32'b000100);
    check("t1_in_handler", 32'(in_handler), 32'd1);
    check("t1_no_reissue", 32'(exccode), 32'(EXC_NONE));
    tick(); settle();
    check("t1_ack_pulse", 32'(ack), 32'd0);
    exit_handler("t1");

    // 2: a synchronous exception wins and defers the interrupt.
    mem_exc = EXC_ADEL;
    int_i   = 6'b000100;
    tick(); tick(); settle();
    check("t2_exccode_adel", 32'(exccode), 32'(EXC_ADEL));
    tick(); settle();
    check("t2_no_ack", 32'(ack), 32'd0);
    check("t2_idle", 32'(in_handler), 32'd0);
    mem_exc = EXC_NONE;
    settle();
    check("t2_exccode_int", 32'(exccode), 32'(EXC_INT));
    tick(); settle();
    check("t2_ack", 32'(ack), 32'b000100);
    mem_exc = EXC_ERET;
    settle();
    check("t2_eret_pass", 32'(exccode), 32'(EXC_ERET));
    tick(); settle();
    check("t2_eret_keeps_state", 32'(in_handler), 32'd1);
    mem_exc = EXC_NONE;
    exit_handler("t2");

    // 3: lines 5 and 0 together -> one issue, highest line acked.
    int_i  = 6'b100001;
    status = 32'h0000_FC01;
    tick(); tick(); settle();
    check("t3_exccode", 32'(exccode), 32'(EXC_INT));
    tick(); settle();
    check("t3_ack", 32'(ack), 32'b100000);
    check("t3_single", 32'(exccode), 32'(EXC_NONE));
    tick(); settle();
    check("t3_ack_pulse", 32'(ack), 32'd0);
    exit_handler("t3");

    // 4: EXL held with line still high -> no re-issue until ERET.
    int_i = 6'b000010;
    tick(); tick(); settle();
    check("t4_exccode", 32'(exccode), 32'(EXC_INT));
    tick(); settle();
    check("t4_ack", 32'(ack), 32'b000010);
    status = 32'h0000_FC03;
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      check("t4_exl_exccode", 32'(exccode), 32'(EXC_NONE));
      check("t4_exl_in_handler", 32'(in_handler), 32'd1);
    end
    status = 32'h0000_FC01;
    settle();
    check("t4_eret_cycle", 32'(exccode), 32'(EXC_NONE));
    tick(); settle();
    check("t4_back_idle", 32'(in_handler), 32'd0);
    check("t4_reissue", 32'(exccode), 32'(EXC_INT));
    tick(); settle();
    check("t4_reack", 32'(ack), 32'b000010);
    exit_handler("t4");

    // Masking: IE=0, EXL=1, IM=0 all block the take; pending stays visible.
    int_i  = 6'b000001;
    status = 32'h0000_FC00;
    tick(); tick(); settle();
    check("mask_pending_visible", 32'(pending), 32'b000001);
    check("mask_ie0", 32'(exccode), 32'(EXC_NONE));
    status = 32'h0000_FC03;
    settle();
    check("mask_exl1", 32'(exccode), 32'(EXC_NONE));
    status = 32'h0000_0001;
    settle();
    check("mask_im0", 32'(exccode), 32'(EXC_NONE));
    // A line that drops before being taken is lost.
    int_i = '0;
    tick(); tick();
    status = 32'h0000_FC01;
    settle();
    check("lost_pending", 32'(pending), 32'd0);
    check("lost_exccode", 32'(exccode), 32'(EXC_NONE));

    // 5: stall and bubble defer the take; reset in HANDLER.
    int_i     = 6'b001000;
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check("t5_stall_exccode", 32'(exccode), 32'(EXC_NONE));
    end
    mem_stall = 1'b0;
    mem_valid = 1'b0;
    tick(); settle();
    check("t5_bubble_exccode", 32'(exccode), 32'(EXC_NONE));
    check("t5_bubble_ack", 32'(ack), 32'd0);
    mem_valid = 1'b1;
    settle();
    check("t5_unstalled", 32'(exccode), 32'(EXC_INT));
    tick(); settle();
    check("t5_ack", 32'(ack), 32'b001000);
    check("t5_in_handler", 32'(in_handler), 32'd1);
    rst = 1'b1;
    tick(); settle();
    check("t5_rst_in_handler", 32'(in_handler), 32'd0);
    check("t5_rst_ack", 32'(ack), 32'd0);
    check("t5_rst_pending", 32'(pending), 32'd0);
    check("t5_rst_exccode", 32'(exccode), 32'(EXC_NONE));
    int_i = '0;
    rst   = 1'b0;
    tick(); tick();

`ifdef CP0_TIMER_EN
    // 6: COUNT=0, COMPARE=8 -> timer request 16 cycles after the COMPARE write.
    begin
      int n;
      status    = 32'h0;
      cp0_we    = 1'b1;
      cp0_waddr = CP0_COUNT;
      cp0_wdata = 32'd0;
      tick();
      cp0_waddr = CP0_COMPARE;
      cp0_wdata = 32'd8;
      tick();
      cp0_we = 1'b0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
        tick(); settle();
        if (pending[5] && n == 0) n = i;
      end
      check("t6_timer_cycles", 32'(n), 32'd16);
      check("t6_timer_pending", 32'(pending), 32'b100000);
      cp0_we    = 1'b1;
      cp0_wdata = 32'd0;
      tick();
      cp0_we = 1'b0;
      settle();
      check("t6_timer_clear", 32'(pending), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
